// File: rtl/cpu_stack_unit.sv
// Hardware stack engine: PUSH/POP/PEEK for spills, atomic two-word CALL/RET frames (bp below pc),
// sticky overflow/underflow flags that block any memory or count change on error.
module cpu_stack_unit #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] cmd_bp,
  output logic             rsp_valid,
  output logic             rsp_err,
  output logic [WIDTH-1:0] rsp_data,
  output logic [WIDTH-1:0] rsp_bp,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             unf
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] OP_PUSH = 3'b001;
  localparam logic [2:0] OP_POP  = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;
  localparam logic [2:0] OP_PEEK = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;

  typedef enum logic [1:0] {IDLE, CALL2, RET2} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] pc_p1;
  logic [WIDTH-1:0] top;
  logic [AW-1:0]    top_idx, push_idx;
  logic [CW-1:0]    count_nxt;
  logic             ovf_nxt, unf_nxt;
  logic             vld_nxt, err_nxt;
  logic [WIDTH-1:0] data_nxt, bp_nxt;
  logic             mem_we, pc_ld;
  logic [WIDTH-1:0] mem_wdata;

  assign cmd_ready = (state == IDLE);
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign top_idx   = AW'(count - CW'(1));
  assign push_idx  = AW'(count);
  assign top       = mem[top_idx];

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    ovf_nxt   = ovf;
    unf_nxt   = unf;
    vld_nxt   = 1'b0;
    err_nxt   = 1'b0;
    data_nxt  = rsp_data;
    bp_nxt    = rsp_bp;
    mem_we    = 1'b0;
    mem_wdata = cmd_data;
    pc_ld     = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_PUSH: begin
              if (!full) begin
                mem_we    = 1'b1;
                count_nxt = count + CW'(1);
              end else begin
                ovf_nxt = 1'b1;
              end
            end
            OP_POP, OP_PEEK: begin
              vld_nxt = 1'b1;
              if (!empty) begin
                data_nxt = top;
                if (cmd_op == OP_POP) count_nxt = count - CW'(1);
              end else begin
                unf_nxt  = 1'b1;
                err_nxt  = 1'b1;
                data_nxt = '0;
              end
            end
            OP_CALL: begin
              // Both words must fit up front so a frame is never half-written.
              if (count <= CW'(DEPTH - 2)) begin
                mem_we    = 1'b1;
                mem_wdata = cmd_bp;
                pc_ld     = 1'b1;
                count_nxt = count + CW'(1);
                state_nxt = CALL2;
              end else begin
                ovf_nxt = 1'b1;
              end
            end
            OP_RET: begin
              if (count >= CW'(2)) begin
                data_nxt  = top;
                count_nxt = count - CW'(1);
                state_nxt = RET2;
              end else begin
                unf_nxt  = 1'b1;
                vld_nxt  = 1'b1;
                err_nxt  = 1'b1;
                data_nxt = '0;
                bp_nxt   = '0;
              end
            end
            OP_CLR: begin
              ovf_nxt = 1'b0;
              unf_nxt = 1'b0;
            end
            default: ;
          endcase
        end
      end
      CALL2: begin
        mem_we    = 1'b1;
        mem_wdata = pc_p1;
        count_nxt = count + CW'(1);
        state_nxt = IDLE;
      end
      RET2: begin
        bp_nxt    = top;
        count_nxt = count - CW'(1);
        vld_nxt   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- control and response registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      rsp_bp    <= '0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      ovf       <= ovf_nxt;
      unf       <= unf_nxt;
      rsp_valid <= vld_nxt;
      rsp_err   <= err_nxt;
      rsp_data  <= data_nxt;
      rsp_bp    <= bp_nxt;
    end
  end

  // ---- storage (not reset) ----
  always_ff @(posedge clk) begin
    if (mem_we) mem[push_idx] <= mem_wdata;
    if (pc_ld)  pc_p1 <= cmd_data;
  end

endmodule

// File: tb/tb_cpu_stack_unit.sv
// Bench for cpu_stack_unit: directed table, corner sequences, mid-CALL reset and random traffic
// checked against a queue-based stack model with timestamped expected responses.
module tb_cpu_stack_unit;
  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, CALL = 3'd3;
  localparam logic [2:0] RET = 3'd4, PEEK = 3'd5, CLR = 3'd6, RSV = 3'd7;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_op = 3'd0;
  logic [WIDTH-1:0] cmd_data = '0;
  logic [WIDTH-1:0] cmd_bp = '0;
  logic             rsp_valid, rsp_err;
  logic [WIDTH-1:0] rsp_data, rsp_bp;
  logic [CW-1:0]    count;
  logic             full, empty, ovf, unf;

  always #5 clk = ~clk;

  cpu_stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_bp(cmd_bp),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data), .rsp_bp(rsp_bp),
    .count(count), .full(full), .empty(empty), .ovf(ovf), .unf(unf)
  );

  int ncmp = 0;
  int nbad = 0;
  int cyc  = 0;
  int nrsp = 0;
  logic             last_err;
  logic [WIDTH-1:0] last_data, last_bp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: stack as a queue, expected responses stamped with the cycle they must appear.
  typedef struct {
    int               due;
    logic             err;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] bp;
  } rsp_t;

  logic [WIDTH-1:0] stk[$];
  rsp_t             expq[$];
  rsp_t             mon_e;
  logic             m_ovf = 1'b0;
  logic             m_unf = 1'b0;
  logic [WIDTH-1:0] m_bp = '0;

  task automatic model(input logic [2:0] op, input logic [WIDTH-1:0] d,
                       input logic [WIDTH-1:0] b, input int c0);
    rsp_t e;
    case (op)
      PUSH: if (stk.size() < DEPTH) stk.push_back(d); else m_ovf = 1'b1;
      POP, PEEK: begin
        e.due = c0 + 1;
        if (stk.size() > 0) begin
          e.err = 1'b0;
          e.data = stk[$];
          if (op == POP) void'(stk.pop_back());
        end else begin
          m_unf = 1'b1;
          e.err = 1'b1;
          e.data = '0;
        end
        e.bp = m_bp;
        expq.push_back(e);
      end
      CALL: begin
        if (stk.size() <= DEPTH - 2) begin
          stk.push_back(b);
          stk.push_back(d);
        end else m_ovf = 1'b1;
      end
      RET: begin
        if (stk.size() >= 2) begin
          e.due = c0 + 2;
          e.err = 1'b0;
          e.data = stk.pop_back();
          e.bp = stk.pop_back();
        end else begin
          e.due = c0 + 1;
          m_unf = 1'b1;
          e.err = 1'b1;
          e.data = '0;
          e.bp = '0;
        end
        m_bp = e.bp;
        expq.push_back(e);
      end
      CLR: begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0 && expq[0].due == cyc) begin
      mon_e = expq.pop_front();
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_err", rsp_err, mon_e.err);
      chk("rsp_data", rsp_data, mon_e.data);
      chk("rsp_bp", rsp_bp, mon_e.bp);
    end else if (rsp_valid) begin
      chk("rsp_valid_spurious", rsp_valid, 0);
    end
    if (rsp_valid) begin
      nrsp++;
      last_err  = rsp_err;
      last_data = rsp_data;
      last_bp   = rsp_bp;
    end
  end

  // Called in the low clock phase; returns in the low phase with the unit idle again.
  task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] d,
                       input logic [WIDTH-1:0] b, output int busy);
    int n;
    int c0;
    n = 0;
    while (!cmd_ready && n < 8) begin @(negedge clk); #1; n++; end
    if (!cmd_ready) chk("ready_timeout_pre", cmd_ready, 1);
    c0 = cyc;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_bp = b;
    @(posedge clk);
    model(op, d, b, c0);
    @(negedge clk); #1;
    cmd_valid = 1'b0;
    busy = 0;
    while (!cmd_ready && busy < 8) begin @(negedge clk); #1; busy++; end
    if (!cmd_ready) chk("ready_timeout_post", cmd_ready, 1);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_count"}, count, stk.size());
    chk({tag, "_full"}, full, stk.size() == DEPTH);
    chk({tag, "_empty"}, empty, stk.size() == 0);
    chk({tag, "_ovf"}, ovf, m_ovf);
    chk({tag, "_unf"}, unf, m_unf);
  endtask

  typedef struct {
    logic [2:0]       op;
    logic [WIDTH-1:0] d, b;
    logic             vld, err;
    logic [WIDTH-1:0] rd, rb;
    int               cnt;
    logic             ovf, unf;
    int               busy;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int busy, nr0;
    //          op    data      bp        vld  err  rdata     rbp       cnt ovf  unf  busy
    tbl[0]  = '{PUSH, 16'h1111, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1, 1'b0, 1'b0, 0};
    tbl[1]  = '{PUSH, 16'h2222, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 2, 1'b0, 1'b0, 0};
    tbl[2]  = '{PUSH, 16'h3333, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 3, 1'b0, 1'b0, 0};
    tbl[3]  = '{POP,  16'h0000, 16'h0000, 1'b1, 1'b0, 16'h3333, 16'h0000, 2, 1'b0, 1'b0, 0};
    tbl[4]  = '{POP,  16'h0000, 16'h0000, 1'b1, 1'b0, 16'h2222, 16'h0000, 1, 1'b0, 1'b0, 0};
    tbl[5]  = '{POP,  16'h0000, 16'h0000, 1'b1, 1'b0, 16'h1111, 16'h0000, 0, 1'b0, 1'b0, 0};
    tbl[6]  = '{CALL, 16'h0040, 16'h0100, 1'b0, 1'b0, 16'h0000, 16'h0000, 2, 1'b0, 1'b0, 1};
    tbl[7]  = '{RET,  16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0040, 16'h0100, 0, 1'b0, 1'b0, 1};
    tbl[8]  = '{POP,  16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0100, 0, 1'b0, 1'b1, 0};
    tbl[9]  = '{CLR,  16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 0, 1'b0, 1'b0, 0};
    tbl[10] = '{RSV,  16'h1234, 16'h5678, 1'b0, 1'b0, 16'h0000, 16'h0000, 0, 1'b0, 1'b0, 0};
    tbl[11] = '{PEEK, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0100, 0, 1'b0, 1'b1, 0};
    tbl[12] = '{PUSH, 16'hABCD, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1, 1'b0, 1'b1, 0};
    tbl[13] = '{PEEK, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'hABCD, 16'h0100, 1, 1'b0, 1'b1, 0};
    tbl[14] = '{CLR,  16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1, 1'b0, 1'b0, 0};
    tbl[15] = '{POP,  16'h0000, 16'h0000, 1'b1, 1'b0, 16'hABCD, 16'h0100, 0, 1'b0, 1'b0, 0};

    // reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_flags", {ovf, unf}, 2'b00);
    chk("rst_rsp", {rsp_valid, rsp_err}, 2'b00);
    chk("rst_rdata", rsp_data, 0);
    chk("rst_rbp", rsp_bp, 0);
    rst_n = 1'b1;
    @(negedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      nr0 = nrsp;
      issue(tbl[i].op, tbl[i].d, tbl[i].b, busy);
      chk($sformatf("tbl%0d_nrsp", i), nrsp - nr0, tbl[i].vld);
      if (tbl[i].vld) begin
        chk($sformatf("tbl%0d_err", i), last_err, tbl[i].err);
        chk($sformatf("tbl%0d_data", i), last_data, tbl[i].rd);
        chk($sformatf("tbl%0d_bp", i), last_bp, tbl[i].rb);
      end
      chk($sformatf("tbl%0d_count", i), count, tbl[i].cnt);
      chk($sformatf("tbl%0d_ovf", i), ovf, tbl[i].ovf);
      chk($sformatf("tbl%0d_unf", i), unf, tbl[i].unf);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("tbl%0d_empty", i), empty, tbl[i].cnt == 0);
    end

    // fill to full, overflow, then PEEK the top
    for (int i = 0; i < 16; i++) issue(PUSH, 16'(i), 16'h0, busy);
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);
    issue(PUSH, 16'hFFFF, 16'h0, busy);
    chk("ovf_set", ovf, 1);
    chk("ovf_count", count, 16);
    nr0 = nrsp;
    issue(PEEK, 16'h0, 16'h0, busy);
    chk("peek_nrsp", nrsp - nr0, 1);
    chk("peek_data", last_data, 16'h000F);
    chk("peek_count", count, 16);
    issue(CLR, 16'h0, 16'h0, busy);
    chk("clr_ovf", ovf, 0);

    // CALL with only one free slot
    issue(POP, 16'h0, 16'h0, busy);
    chk("c15_count_pre", count, 15);
    issue(CALL, 16'h0200, 16'h0300, busy);
    chk("c15_ovf", ovf, 1);
    chk("c15_count", count, 15);
    chk("c15_busy", busy, 0);
    issue(CLR, 16'h0, 16'h0, busy);

    // RET with a single entry
    for (int i = 0; i < 14; i++) issue(POP, 16'h0, 16'h0, busy);
    chk("r1_count_pre", count, 1);
    nr0 = nrsp;
    issue(RET, 16'h0, 16'h0, busy);
    chk("r1_unf", unf, 1);
    chk("r1_nrsp", nrsp - nr0, 1);
    chk("r1_err", last_err, 1);
    chk("r1_data", last_data, 0);
    chk("r1_bp", last_bp, 0);
    chk("r1_count", count, 1);
    chk("r1_busy", busy, 0);
    issue(CLR, 16'h0, 16'h0, busy);
    issue(POP, 16'h0, 16'h0, busy);
    check_state("drain");

    // async reset while in CALL2
    cmd_valid = 1'b1; cmd_op = CALL; cmd_data = 16'h0055; cmd_bp = 16'h0066;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("mid_ready", cmd_ready, 0);
    chk("mid_count", count, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_rsp", rsp_valid, 0);
    chk("mid_rst_rdata", rsp_data, 0);
    chk("mid_rst_flags", {ovf, unf}, 2'b00);
    stk.delete(); expq.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_bp = '0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_ready", cmd_ready, 1);
    chk("post_rst_count", count, 0);
    chk("post_rst_rsp", rsp_valid, 0);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) op = PUSH;
      issue(op, 16'($urandom), 16'($urandom), busy);
      check_state($sformatf("rnd%0d", i));
    end

    repeat (3) @(negedge clk);
    chk("expq_drained", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", ncmp, nbad);
    $fatal(1);
  end

endmodule

// File: doc/cpu_stack_unit.md
Name: cpu_stack_unit

Overview:
- Parametrised hardware stack engine for the CPU core; replaces the ad-hoc stack array and stack-pointer arithmetic in the datapath.
- Serves PUSH/POP/PEEK for register spills and atomic two-word CALL/RET frames holding pc and bp.
- Detects overflow and underflow and raises sticky flags instead of corrupting memory.
- Sits between the CPU FSM, which issues commands, and a private stack RAM.

Parameters:
- WIDTH, 16, data word width in bits (pc, bp and register width).
- DEPTH, 16, number of stack entries; must be >= 2.
- CW, $clog2(DEPTH+1), derived width of the occupancy count; not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  unit can accept a command this cycle.
- cmd_op  input  3  op code: 000 NOP, 001 PUSH, 010 POP, 011 CALL, 100 RET, 101 PEEK, 110 CLR_ERR, 111 reserved (executes as NOP).
- cmd_data  input  WIDTH  PUSH data, or the pc to save on CALL.
- cmd_bp  input  WIDTH  bp to save on CALL.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_err  output  1  the response belongs to a failed POP, PEEK or RET.
- rsp_data  output  WIDTH  POP/PEEK value, or the restored pc on RET.
- rsp_bp  output  WIDTH  restored bp on RET.
- count  output  CW  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- ovf  output  1  sticky overflow flag.
- unf  output  1  sticky underflow flag.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, count=0, ovf=0, unf=0.
  - rsp_valid=0, rsp_err=0, rsp_data=0, rsp_bp=0.
  - Stack RAM is not cleared.
  - Reset mid-CALL/RET abandons the operation; no response is emitted.
- Handshake:
  - A command is accepted when cmd_valid && cmd_ready.
  - cmd_ready=1 only in IDLE.
  - A command presented while cmd_ready=0 is held by the issuer; it is not dropped.
  - rsp_valid has no backpressure.
- States: IDLE, CALL2, RET2.
- Storage layout: entries mem[0..DEPTH-1]; top of stack is mem[count-1]; the stack grows upward.
- PUSH:
  - If count<DEPTH: mem[count]<=cmd_data, count+1.
  - Else: ovf<=1, no write, count unchanged.
  - No response.
- POP:
  - If count>0: rsp_data<=mem[count-1], count-1, rsp_valid=1 on the next cycle (latency 1).
  - Else: unf<=1, rsp_valid=1, rsp_err=1, rsp_data=0.
- PEEK: same as POP but count is unchanged.
- CALL (atomic, 2 cycles):
  - Requires count<=DEPTH-2, checked at accept.
  - Accept cycle: mem[count]<=cmd_bp, count+1, latch cmd_data, go to CALL2.
  - CALL2: mem[count]<=latched pc, count+1, return to IDLE.
  - If fewer than 2 entries are free: ovf<=1, nothing written, stay in IDLE.
  - No response.
- RET (atomic, 2 cycles):
  - Requires count>=2, checked at accept.
  - Accept cycle: rsp_data<=mem[count-1] (pc), count-1, go to RET2.
  - RET2: rsp_bp<=mem[count-1], count-1, return to IDLE.
  - rsp_valid=1 the cycle after RET2, i.e. 2 cycles after accept.
  - If count<2: unf<=1, rsp_valid=1 with rsp_err=1 after 1 cycle; rsp_data and rsp_bp=0; count unchanged.
- CLR_ERR: ovf<=0 and unf<=0 on the next edge; no other effect.
- rsp_err is 0 on every successful response; rsp_data and rsp_bp hold their value between responses.
- Flags:
  - full and empty are combinational from count.
  - ovf and unf stay set until CLR_ERR or reset.
  - Errors never modify count or memory.
- Arithmetic: count never wraps; all boundary checks are made before the update.

Test Plan:
- Reset, PUSH 0x1111, 0x2222, 0x3333, then POP x3 -> rsp_data 0x3333, 0x2222, 0x1111, each 1 cycle after accept; count 3->0; empty=1.
- DEPTH=16, 16 PUSHes of 0x00..0x0F -> full=1; 17th PUSH 0xFFFF -> ovf=1, count=16, PEEK returns 0x000F.
- CALL cmd_data=0x0040, cmd_bp=0x0100, then RET -> cmd_ready low for 1 cycle on each; rsp_valid 2 cycles after RET accept with rsp_data=0x0040, rsp_bp=0x0100, rsp_err=0; count 0->2->0.
- POP on empty -> rsp_valid=1, rsp_err=1, rsp_data=0, unf=1; CLR_ERR -> unf=0 the next cycle.
- CALL at count=15 -> ovf=1, count stays 15, no state change; RET at count=1 -> unf=1, rsp_err pulse, count stays 1.
- Assert rst_n low during CALL2 -> count=0 immediately; no rsp_valid; cmd_ready=1 after release.
